c0_control_sequencer: RTL and testbench

// Multi-cycle fetch/decode/execute sequencer for the C0 8-bit datapath. Fetches instruction bytes over a req/ack

---
 rtl/c0_control_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_c0_control_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c0_control_sequencer.sv
// C0 control sequencer: multi-cycle fetch/decode/execute controller for the
// 8-bit C0 datapath. Fetches instruction bytes over a req/ack port, holds
// PC/IR/immediate/zero flag and drives the register-file mux/decoder selects.
module c0_control_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       alu_zero,
    output logic [2:0] src_sel,
    output logic [2:0] wr_sel,
    output logic       wr_en,
    output logic [1:0] res_sel,
    output logic [7:0] imm,
    output logic [7:0] pc,
    output logic       halted,
    output logic       fault
);

    // Major opcode field ir[7:6]
    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_CTL = 2'b11;

    // Control sub-opcode field ir[5:3] when ir[7:6] == OP_CTL
    localparam logic [2:0] CTL_HALT = 3'b000;
    localparam logic [2:0] CTL_JMP  = 3'b001;
    localparam logic [2:0] CTL_JZ   = 3'b010;

    // Result mux encodings
    localparam logic [1:0] RES_REG  = 2'd0;
    localparam logic [1:0] RES_ALU  = 2'd1;
    localparam logic [1:0] RES_IMM  = 2'd2;

    // Wait counter limit; the counter is 4 bits wide since the limit is 1..15
    localparam logic [3:0] ACK_LIMIT = 4'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_FETCH2 = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  pc_r;
    logic [7:0]  ir_r;
    logic [7:0]  imm_r;
    logic        zflag_r;
    logic [3:0]  wait_cnt_r;
    logic        mem_req_r;
    logic        wr_en_r;
    logic [1:0]  res_sel_r;
    logic        halted_r;
    logic        fault_r;

    // Instruction needs a second (immediate) byte: LDI, JMP, JZ
    function automatic logic is_two_byte(input logic [7:0] op);
        logic two_s;
        case (op[7:6])
            OP_LDI:  two_s = 1'b1;
            OP_CTL:  two_s = (op[5:3] == CTL_JMP) || (op[5:3] == CTL_JZ);
            default: two_s = 1'b0;
        endcase
        return two_s;
    endfunction

    // Instruction writes the register file in EXEC: MOV, ADD, LDI
    function automatic logic is_write(input logic [7:0] op);
        return (op[7:6] != OP_CTL);
    endfunction

    // Instruction is HALT
    function automatic logic is_halt(input logic [7:0] op);
        return (op[7:6] == OP_CTL) && (op[5:3] == CTL_HALT);
    endfunction

    // Result mux select used during EXEC for a given instruction
    function automatic logic [1:0] exec_res_sel(input logic [7:0] op);
        logic [1:0] sel_s;
        case (op[7:6])
            OP_MOV:  sel_s = RES_REG;
            OP_ADD:  sel_s = RES_ALU;
            OP_LDI:  sel_s = RES_IMM;
            default: sel_s = RES_REG;
        endcase
        return sel_s;
    endfunction

    // Next-state decision; ack beats the timeout when both land in one cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_nxt_s = ST_DECODE;
                end else if (wait_cnt_r == ACK_LIMIT) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_two_byte(ir_r)) begin
                    state_nxt_s = ST_FETCH2;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_FETCH2: begin
                if (mem_ack) begin
                    state_nxt_s = ST_EXEC;
                end else if (wait_cnt_r == ACK_LIMIT) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_FETCH2;
                end
            end
            ST_EXEC: begin
                if (is_halt(ir_r)) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HALT:  state_nxt_s = ST_HALT;
            ST_FAULT: state_nxt_s = ST_FAULT;
            default:  state_nxt_s = ST_FAULT;
        endcase
    end

    // State, datapath registers and registered strobes derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            ir_r       <= 8'h00;
            imm_r      <= 8'h00;
            zflag_r    <= 1'b0;
            wait_cnt_r <= 4'd0;
            mem_req_r  <= 1'b0;
            wr_en_r    <= 1'b0;
            res_sel_r  <= RES_REG;
            halted_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mem_req_r <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_FETCH2);
            wr_en_r   <= (state_nxt_s == ST_EXEC) && is_write(ir_r);
            res_sel_r <= (state_nxt_s == ST_EXEC) ? exec_res_sel(ir_r) : RES_REG;
            halted_r  <= (state_nxt_s == ST_HALT);
            fault_r   <= (state_nxt_s == ST_FAULT);

            // Count only unacknowledged request cycles that stay in the same fetch state
            if (((state_r == ST_FETCH) || (state_r == ST_FETCH2)) && !mem_ack &&
                (state_nxt_s == state_r)) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end

            case (state_r)
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir_r <= mem_rdata;
                        pc_r <= pc_r + 8'd1;
                    end
                end
                ST_FETCH2: begin
                    if (mem_ack) begin
                        imm_r <= mem_rdata;
                        pc_r  <= pc_r + 8'd1;
                    end
                end
                ST_EXEC: begin
                    if (ir_r[7:6] == OP_ADD) begin
                        zflag_r <= alu_zero;
                    end else if ((ir_r[7:6] == OP_CTL) && (ir_r[5:3] == CTL_JMP)) begin
                        pc_r <= imm_r;
                    end else if ((ir_r[7:6] == OP_CTL) && (ir_r[5:3] == CTL_JZ) && zflag_r) begin
                        pc_r <= imm_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_req_r ? pc_r : 8'h00;
    assign src_sel  = ir_r[2:0];
    assign wr_sel   = ir_r[5:3];
    assign wr_en    = wr_en_r;
    assign res_sel  = res_sel_r;
    assign imm      = imm_r;
    assign pc       = pc_r;
    assign halted   = halted_r;
    assign fault    = fault_r;

endmodule

// File: tb/tb_c0_control_sequencer.sv
// Directed bench for c0_control_sequencer: walks a short program through the
// sequencer, pushing expected EXEC-cycle outputs to a scoreboard queue when an
// instruction is issued and popping them when the DUT reaches EXEC.
module tb_c0_control_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       alu_zero;
    logic [2:0] src_sel;
    logic [2:0] wr_sel;
    logic       wr_en;
    logic [1:0] res_sel;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       halted;
    logic       fault;

    int total;
    int bad;

    typedef struct packed {
        logic       wr_en;
        logic [2:0] wr_sel;
        logic [2:0] src_sel;
        logic [1:0] res_sel;
        logic [7:0] imm;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];

    c0_control_sequencer #(
        .RESET_PC   (8'h00),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .alu_zero (alu_zero),
        .src_sel  (src_sel),
        .wr_sel   (wr_sel),
        .wr_en    (wr_en),
        .res_sel  (res_sel),
        .imm      (imm),
        .pc       (pc),
        .halted   (halted),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [2:0] ws, input logic [2:0] ss,
                        input logic [1:0] rs, input logic [7:0] im, input logic [7:0] p);
        exp_t e;
        e = '{wr_en: we, wr_sel: ws, src_sel: ss, res_sel: rs, imm: im, pc: p};
        sb.push_back(e);
    endtask

    // Serve one fetch: expects DUT in FETCH/FETCH2 now, leaves it one cycle after ack
    task automatic serve(input logic [7:0] addr, input logic [7:0] data, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_addr", 32'(mem_addr), 32'(addr));
            mem_ack = 1'b0;
            step();
        end
        chk("ack_req", 32'(mem_req), 32'd1);
        chk("ack_addr", 32'(mem_addr), 32'(addr));
        chk("ack_fault", 32'(fault), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
    endtask

    // Pop the scoreboard and compare against the EXEC-cycle outputs
    task automatic check_exec();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("exec_wr_en", 32'(wr_en), 32'(e.wr_en));
            chk("exec_wr_sel", 32'(wr_sel), 32'(e.wr_sel));
            chk("exec_src_sel", 32'(src_sel), 32'(e.src_sel));
            chk("exec_res_sel", 32'(res_sel), 32'(e.res_sel));
            chk("exec_imm", 32'(imm), 32'(e.imm));
            chk("exec_pc", 32'(pc), 32'(e.pc));
            chk("exec_req", 32'(mem_req), 32'd0);
        end
    endtask

    // Run one full instruction from FETCH through EXEC; leaves DUT one cycle after EXEC
    task automatic run_instr(input logic [7:0] addr, input logic [7:0] op, input logic [7:0] b2,
                             input int w1, input int w2, input logic zero);
        serve(addr, op, w1);
        chk("dec_req", 32'(mem_req), 32'd0);
        chk("dec_wr_en", 32'(wr_en), 32'd0);
        step();
        if ((op[7:6] == 2'b10) || ((op[7:6] == 2'b11) && ((op[5:3] == 3'b001) || (op[5:3] == 3'b010)))) begin
            serve(addr + 8'd1, b2, w2);
        end
        alu_zero = zero;
        check_exec();
        step();
        alu_zero = 1'b0;
        chk("post_wr_en", 32'(wr_en), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        alu_zero  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            step();
        end
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_res_sel", 32'(res_sel), 32'd0);
        chk("rst_imm", 32'(imm), 32'h00);

        // Start: first fetch at 00
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_req", 32'(mem_req), 32'd1);
        chk("start_addr", 32'(mem_addr), 32'h00);

        // MOV r3,r5 with 2 wait cycles
        push(1'b1, 3'd3, 3'd5, 2'd0, 8'h00, 8'h01);
        run_instr(8'h00, 8'h1D, 8'h00, 2, 0, 1'b0);
        // LDI r2,5A
        push(1'b1, 3'd2, 3'd0, 2'd2, 8'h5A, 8'h03);
        run_instr(8'h01, 8'h90, 8'h5A, 0, 1, 1'b0);
        // ADD r1,r2 with zero result
        push(1'b1, 3'd1, 3'd2, 2'd1, 8'h5A, 8'h04);
        run_instr(8'h03, 8'h4A, 8'h00, 0, 0, 1'b1);
        // JZ 40 taken
        push(1'b0, 3'd2, 3'd0, 2'd0, 8'h40, 8'h06);
        run_instr(8'h04, 8'hD0, 8'h40, 1, 0, 1'b0);
        chk("jz_taken_pc", 32'(pc), 32'h40);
        // ADD r1,r2 with nonzero result
        push(1'b1, 3'd1, 3'd2, 2'd1, 8'h40, 8'h41);
        run_instr(8'h40, 8'h4A, 8'h00, 0, 0, 1'b0);
        // JZ 80 not taken: falls through to 43
        push(1'b0, 3'd2, 3'd0, 2'd0, 8'h80, 8'h43);
        run_instr(8'h41, 8'hD0, 8'h80, 0, 0, 1'b0);
        chk("jz_fall_pc", 32'(pc), 32'h43);
        // JMP FE
        push(1'b0, 3'd1, 3'd0, 2'd0, 8'hFE, 8'h45);
        run_instr(8'h43, 8'hC8, 8'hFE, 0, 0, 1'b0);
        chk("jmp_pc", 32'(pc), 32'hFE);
        // NOP at FE
        push(1'b0, 3'd7, 3'd0, 2'd0, 8'hFE, 8'hFF);
        run_instr(8'hFE, 8'hF8, 8'h00, 0, 0, 1'b0);

        // JMP at FF acked exactly on the limit cycle; pc wraps to 00
        serve(8'hFF, 8'hC8, 15);
        chk("limit_no_fault", 32'(fault), 32'd0);
        chk("wrap_pc", 32'(pc), 32'h00);
        step();
        chk("f2_wrap_addr", 32'(mem_addr), 32'h00);
        // Immediate byte never acked: 16 request cycles then FAULT
        for (int i = 0; i < 16; i++) begin
            chk("to_req", 32'(mem_req), 32'd1);
            chk("to_fault", 32'(fault), 32'd0);
            step();
        end
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_req", 32'(mem_req), 32'd0);
        start   = 1'b1;
        mem_ack = 1'b1;
        step();
        step();
        start   = 1'b0;
        mem_ack = 1'b0;
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_no_req", 32'(mem_req), 32'd0);
        chk("fault_pc", 32'(pc), 32'h00);

        // Reset clears fault
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_fault", 32'(fault), 32'd0);
        chk("rst2_pc", 32'(pc), 32'h00);

        // HALT
        start = 1'b1;
        step();
        start = 1'b0;
        push(1'b0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h01);
        run_instr(8'h00, 8'hC0, 8'h00, 0, 0, 1'b0);
        chk("halted", 32'(halted), 32'd1);
        chk("halt_req", 32'(mem_req), 32'd0);
        start = 1'b1;
        step();
        step();
        step();
        start = 1'b0;
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(mem_req), 32'd0);
        chk("halt_pc", 32'(pc), 32'h01);

        // Reset during a pending fetch request, then a late ack
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pend_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_pc", 32'(pc), 32'h00);
        chk("midrst_halted", 32'(halted), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 8'h4A;
        step();
        mem_ack   = 1'b0;
        step();
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_pc", 32'(pc), 32'h00);
        chk("late_ack_src", 32'(src_sel), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
